// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes N_NEURONS neurons onto one external neuron datapath, holding
// each neuron's weight vector, membrane potential and last spike flag locally.
module neuron_layer_sequencer #(
  parameter int n_stage   = 2,
  parameter int N_NEURONS = 4,
  localparam int WX = 2 ** n_stage,
  localparam int UW = n_stage + 2,
  localparam int IW = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WX-1:0]        x_in,
  input  logic                 w_we,
  input  logic [IW-1:0]        w_addr,
  input  logic [WX-1:0]        w_data,
  input  logic                 clear,
  output logic [WX-1:0]        nrn_w,
  output logic [WX-1:0]        nrn_x,
  output logic [UW-1:0]        nrn_previus_u,
  output logic                 nrn_was_spike,
  input  logic [UW-1:0]        nrn_u_out,
  input  logic                 nrn_is_spike,
  output logic [IW-1:0]        nrn_idx,
  output logic [N_NEURONS-1:0] spikes_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WX-1:0]        x_q, x_d;
  logic [WX-1:0]        w_mem_q [N_NEURONS];
  logic [WX-1:0]        w_mem_d [N_NEURONS];
  logic [UW-1:0]        u_mem_q [N_NEURONS];
  logic [UW-1:0]        u_mem_d [N_NEURONS];
  logic [N_NEURONS-1:0] s_mem_q, s_mem_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    w_mem_d  = w_mem_q;
    u_mem_d  = u_mem_q;
    s_mem_d  = s_mem_q;
    spikes_d = spikes_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A weight written alongside start lands before the first RUN read.
        if (w_we) begin
          w_mem_d[w_addr] = w_data;
        end
        if (clear) begin
          for (int i = 0; i < N_NEURONS; i++) begin
            u_mem_d[i] = '0;
          end
          s_mem_d = '0;
        end else if (start) begin
          state_d = RUN;
          x_d     = x_in;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        u_mem_d[idx_q] = nrn_u_out;
        s_mem_d[idx_q] = nrn_is_spike;
        if (idx_q == LAST_IDX) begin
          // Publish the spike vector including the neuron written on this edge.
          state_d  = DONE;
          idx_d    = '0;
          done_d   = 1'b1;
          spikes_d = s_mem_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      s_mem_q  <= '0;
      spikes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        w_mem_q[i] <= '0;
        u_mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      s_mem_q  <= s_mem_d;
      spikes_q <= spikes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      for (int i = 0; i < N_NEURONS; i++) begin
        w_mem_q[i] <= w_mem_d[i];
        u_mem_q[i] <= u_mem_d[i];
      end
    end
  end

  assign nrn_idx       = idx_q;
  assign nrn_w         = w_mem_q[idx_q];
  assign nrn_x         = x_q;
  assign nrn_previus_u = u_mem_q[idx_q];
  assign nrn_was_spike = s_mem_q[idx_q];
  assign spikes_out    = spikes_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Scoreboard bench for neuron_layer_sequencer: stimulus queues the expected
// per-cycle neuron beats, a negedge monitor pops and compares them.
module tb_neuron_layer_sequencer;

   localparam int N  = 4;
   localparam int WX = 4;
   localparam int UW = 4;
   localparam int IW = 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [WX-1:0] x_in;
   logic          w_we;
   logic [IW-1:0] w_addr;
   logic [WX-1:0] w_data;
   logic          clear;
   logic [WX-1:0] nrn_w;
   logic [WX-1:0] nrn_x;
   logic [UW-1:0] nrn_previus_u;
   logic          nrn_was_spike;
   logic [UW-1:0] nrn_u_out;
   logic          nrn_is_spike;
   logic [IW-1:0] nrn_idx;
   logic [N-1:0]  spikes_out;
   logic          busy;
   logic          done;

   typedef struct {
      bit            is_done;
      logic [IW-1:0] idx;
      logic [WX-1:0] w;
      logic [WX-1:0] x;
      logic [UW-1:0] u;
      logic          s;
      logic [N-1:0]  spk;
   } beat_t;

   beat_t sb[$];

   int compared;
   int failed;
   int doneSeen;
   int doneExpected;

   logic [WX-1:0] wModel [N];
   logic [UW-1:0] uModel [N];
   logic [N-1:0]  sModel;
   logic [N-1:0]  spikesModel;

   neuron_layer_sequencer #(
      .n_stage   (2),
      .N_NEURONS (N)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .x_in          (x_in),
      .w_we          (w_we),
      .w_addr        (w_addr),
      .w_data        (w_data),
      .clear         (clear),
      .nrn_w         (nrn_w),
      .nrn_x         (nrn_x),
      .nrn_previus_u (nrn_previus_u),
      .nrn_was_spike (nrn_was_spike),
      .nrn_u_out     (nrn_u_out),
      .nrn_is_spike  (nrn_is_spike),
      .nrn_idx       (nrn_idx),
      .spikes_out    (spikes_out),
      .busy          (busy),
      .done          (done)
   );

   // Stand-in datapath: new potential is idx+5, spike is the low index bit
   assign nrn_u_out    = UW'(32'(nrn_idx) + 5);
   assign nrn_is_spike = nrn_idx[0];

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point shared by stimulus and monitor
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then return to quiet inputs just after the edge
   task automatic applyStimulus(input logic s, input logic [WX-1:0] x,
                                input logic we, input logic [IW-1:0] addr,
                                input logic [WX-1:0] data, input logic clr);
      start  = s;
      x_in   = x;
      w_we   = we;
      w_addr = addr;
      w_data = data;
      clear  = clr;
      @(posedge clk);
      #1;
      start  = 1'b0;
      x_in   = '0;
      w_we   = 1'b0;
      w_addr = '0;
      w_data = '0;
      clear  = 1'b0;
   endtask

   task automatic writeWeight(input logic [IW-1:0] addr, input logic [WX-1:0] data);
      wModel[addr] = data;
      applyStimulus(1'b0, '0, 1'b1, addr, data, 1'b0);
   endtask

   // Queue the beats this timestep should produce, then issue start
   task automatic startStep(input logic [WX-1:0] x, input logic we,
                            input logic [IW-1:0] addr, input logic [WX-1:0] data,
                            input int nBeats);
      beat_t b;
      if (we) wModel[addr] = data;
      for (int i = 0; i < nBeats; i++) begin
         b.is_done = 1'b0;
         b.idx     = IW'(i);
         b.w       = wModel[i];
         b.x       = x;
         b.u       = uModel[i];
         b.s       = sModel[i];
         b.spk     = spikesModel;
         sb.push_back(b);
      end
      if (nBeats == N) begin
         for (int i = 0; i < N; i++) begin
            uModel[i] = UW'(i + 5);
            sModel[i] = i[0];
         end
         spikesModel = sModel;
         b.is_done = 1'b1;
         b.idx     = '0;
         b.w       = '0;
         b.x       = '0;
         b.u       = '0;
         b.s       = 1'b0;
         b.spk     = spikesModel;
         sb.push_back(b);
         doneExpected++;
      end
      applyStimulus(1'b1, x, we, addr, data, 1'b0);
   endtask

   // Wait for done with a cycle budget; expCycles<0 skips the latency check
   task automatic waitDone(input int expCycles);
      int cycles;
      cycles = 0;
      while (cycles < 20) begin
         @(negedge clk);
         cycles++;
         if (done) break;
      end
      if (!done) begin
         compared++;
         failed++;
         $display("[TB] FAIL done_timeout: no done within %0d cycles, required a pulse", cycles);
      end else if (expCycles >= 0) begin
         checkOutput("done_latency", cycles, expCycles);
      end
      @(negedge clk);
      checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
      checkOutput("done_single_pulse", {31'd0, done}, 32'd0);
   endtask

   // Monitor: every busy cycle is one expected beat
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n && busy) begin
            if (sb.size() == 0) begin
               compared++;
               failed++;
               $display("[TB] FAIL unexpected_beat: busy=1 done=%b idx=%0d, required idle", done, nrn_idx);
            end else begin
               e = sb.pop_front();
               checkOutput("beat_kind", {31'd0, done}, {31'd0, e.is_done});
               if (e.is_done) begin
                  checkOutput("spikes_out_done", {28'd0, spikes_out}, {28'd0, e.spk});
               end else begin
                  checkOutput("nrn_idx", {30'd0, nrn_idx}, {30'd0, e.idx});
                  checkOutput("nrn_w", {28'd0, nrn_w}, {28'd0, e.w});
                  checkOutput("nrn_x", {28'd0, nrn_x}, {28'd0, e.x});
                  checkOutput("nrn_previus_u", {28'd0, nrn_previus_u}, {28'd0, e.u});
                  checkOutput("nrn_was_spike", {31'd0, nrn_was_spike}, {31'd0, e.s});
                  checkOutput("spikes_out_hold", {28'd0, spikes_out}, {28'd0, e.spk});
               end
            end
         end
         if (done) doneSeen++;
      end
   end

   initial begin
      bit found;
      compared     = 0;
      failed       = 0;
      doneSeen     = 0;
      doneExpected = 0;
      for (int i = 0; i < N; i++) begin
         wModel[i] = '0;
         uModel[i] = '0;
      end
      sModel      = '0;
      spikesModel = '0;

      // Reset with random inputs
      rst_n  = 1'b0;
      start  = 1'($urandom);
      x_in   = WX'($urandom);
      w_we   = 1'($urandom);
      w_addr = IW'($urandom);
      w_data = WX'($urandom);
      clear  = 1'($urandom);
      repeat (2) @(negedge clk);
      checkOutput("rst_spikes_out", {28'd0, spikes_out}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_previus_u", {28'd0, nrn_previus_u}, 32'd0);
      checkOutput("rst_idx", {30'd0, nrn_idx}, 32'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      start  = 1'b0;
      x_in   = '0;
      w_we   = 1'b0;
      w_addr = '0;
      w_data = '0;
      clear  = 1'b0;

      // Sequencing: weights 1..4, start with 1010
      $display("[TB] sequencing");
      for (int i = 0; i < N; i++) writeWeight(IW'(i), WX'(i + 1));
      startStep(4'b1010, 1'b0, '0, '0, N);
      waitDone(5);
      checkOutput("spikes_first", {28'd0, spikes_out}, 32'b1010);

      // Ignored start and weight write during RUN
      $display("[TB] ignored requests");
      startStep(4'b0110, 1'b0, '0, '0, N);
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 4'hF, 1'b1, 2'd2, 4'hF, 1'b0);
      waitDone(-1);
      repeat (3) @(negedge clk);
      startStep(4'b0011, 1'b0, '0, '0, N);
      waitDone(5);

      // Clear has priority over start
      $display("[TB] clear vs start");
      applyStimulus(1'b1, 4'b1111, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < N; i++) uModel[i] = '0;
      sModel = '0;
      @(negedge clk);
      checkOutput("clear_no_busy", {31'd0, busy}, 32'd0);
      startStep(4'b1100, 1'b0, '0, '0, N);
      waitDone(5);

      // Reset mid-run at idx 2
      $display("[TB] reset mid-run");
      startStep(4'b0101, 1'b0, '0, '0, 3);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (busy && nrn_idx == 2'd2) found = 1'b1;
      end
      if (!found) begin
         compared++;
         failed++;
         $display("[TB] FAIL idx2_timeout: idx 2 never reached, required within 10 cycles");
      end
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         wModel[i] = '0;
         uModel[i] = '0;
      end
      sModel      = '0;
      spikesModel = '0;
      @(negedge clk);
      checkOutput("midrst_spikes_out", {28'd0, spikes_out}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_idx", {30'd0, nrn_idx}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midrst_spikes_hold", {28'd0, spikes_out}, 32'd0);

      // Weight write together with start is used in this timestep
      $display("[TB] write with start");
      startStep(4'b1111, 1'b1, 2'd0, 4'h9, N);
      waitDone(5);
      checkOutput("spikes_last", {28'd0, spikes_out}, 32'b1010);

      repeat (3) @(negedge clk);
      checkOutput("queue_empty", sb.size(), 32'd0);
      checkOutput("done_count", doneSeen, doneExpected);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
